tdm_demux: RTL

// - Time-division demultiplexer: receive end of the 4:1 mux line. One serial

---
 rtl/tdm_demux.sv | 115 +++++++++++
 1 files changed

// File: rtl/tdm_demux.sv
// Receive side of a TDM link: rebuilds the parallel word from serial slots aligned by a frame sync.
// Optional SYNC_CHECK_EN adds err/err_cnt reporting of misaligned sync pulses.
module tdm_demux #(
  parameter int CH     = 4,
  parameter int SEL_W  = 2,
  parameter int DATA_W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sync,
  input  logic [DATA_W-1:0]    din,
  output logic [CH*DATA_W-1:0] dout,
  output logic                 valid,
  output logic [SEL_W-1:0]     sel,
  output logic                 locked
`ifdef SYNC_CHECK_EN
  ,
  output logic                 err,
  output logic [7:0]           err_cnt
`endif
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CH - 1);

  state_e                      state_q, state_d;
  logic [SEL_W-1:0]            slot_q, slot_d;
  // The last slot is never stored: it goes straight from din into dout.
  logic [(CH-1)*DATA_W-1:0]    shadow_q, shadow_d;
  logic [CH*DATA_W-1:0]        dout_q, dout_d;
  logic                        valid_q, valid_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;

    if (en) begin
      if (sync) begin
        // Frame start (aligned or not) always restarts the frame at slot 0.
        state_d                 = LOCKED;
        shadow_d[DATA_W-1:0]    = din;
        slot_d                  = SEL_W'(1);
      end else if (state_q == LOCKED) begin
        if (slot_q == LAST_SLOT) begin
          slot_d  = '0;
          dout_d  = {din, shadow_q};
          valid_d = 1'b1;
        end else begin
          for (int k = 0; k < CH - 1; k++) begin
            if (slot_q == SEL_W'(k)) shadow_d[k*DATA_W +: DATA_W] = din;
          end
          slot_d = slot_q + SEL_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  // NOTE: the shadow store is a handful of flops, so it is reset along with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  assign dout   = dout_q;
  assign valid  = valid_q;
  assign sel    = slot_q;
  assign locked = (state_q == LOCKED);

`ifdef SYNC_CHECK_EN
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // A sync landing anywhere but slot 0 while locked is a misalignment; a missing sync is not.
  always_comb begin
    err_d     = en && sync && (state_q == LOCKED) && (slot_q != '0);
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
